// File: rtl/rr_req_agent_if.sv
// Requester-agent bus: job offers in, arbiter req/grant, completion and error reporting.
// The agent takes the slave side; the environment (jobs + arbiter) takes the master side.
interface rr_req_agent_if #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]     job_valid;
  logic [N-1:0]     job_ready;
  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic             done_valid;
  logic [IDX_W-1:0] done_id;
  logic [N-1:0]     starve;
  logic             err_spurious;
  logic             err_multi;
  logic             clr_err;

  modport slave (
    input  job_valid, grant, clr_err,
    output job_ready, req, done_valid, done_id, starve, err_spurious, err_multi
  );

  modport master (
    output job_valid, grant, clr_err,
    input  job_ready, req, done_valid, done_id, starve, err_spurious, err_multi
  );
endinterface

// File: rtl/rr_req_agent.sv
// Requester-side agent for a round-robin arbiter. Keeps a saturating pending count per
// channel, requests while work is queued, consumes one-hot grants and reports completions,
// protocol errors and per-channel starvation.
module rr_req_agent #(
  parameter int N          = 4,
  parameter int CNT_W      = 4,
  parameter int STARVE_LIM = 16,
  localparam int IDX_W     = (N > 1) ? $clog2(N) : 1,
  localparam int WAIT_W    = $clog2(STARVE_LIM + 1)
) (
  input logic           clk,
  input logic           reset,
  rr_req_agent_if.slave bus
);

  localparam logic [CNT_W-1:0]  MAX_CNT = {CNT_W{1'b1}};
  localparam logic [WAIT_W-1:0] LIM     = WAIT_W'(STARVE_LIM);

  logic [CNT_W-1:0]  pending   [N];
  logic [WAIT_W-1:0] wait_cnt  [N];
  logic [WAIT_W-1:0] wait_next [N];

  logic [N-1:0]     accept;
  logic [N-1:0]     consume;
  logic [N-1:0]     req_int;
  logic [N-1:0]     starve_q;
  logic             spurious_hit;
  logic             multi_hit;
  logic             err_spurious_q;
  logic             err_multi_q;
  logic             done_valid_q;
  logic [IDX_W-1:0] done_id_q;
  logic [IDX_W-1:0] first_idx;

  // Per-channel handshake, request shaping and consume/accept decode.
  // A granted channel only keeps requesting if a second job is queued, which covers the
  // arbiter's one-cycle grant latency without ever earning a grant for an empty queue.
  always_comb begin
    accept       = '0;
    consume      = '0;
    req_int      = '0;
    spurious_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      accept[i]  = bus.job_valid[i] && (pending[i] != MAX_CNT);
      consume[i] = bus.grant[i] && (pending[i] != '0);
      req_int[i] = bus.grant[i] ? (pending[i] > CNT_W'(1)) : (pending[i] != '0);
      if (bus.grant[i] && (pending[i] == '0)) spurious_hit = 1'b1;
    end
    multi_hit = (bus.grant & (bus.grant - N'(1))) != '0;
  end

  // Lowest consumed channel index, used as the completion id.
  always_comb begin
    first_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (consume[i]) first_idx = IDX_W'(i);
    end
  end

  // Next wait count: grows while requesting unserved, saturates at the limit, else clears.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wait_next[i] = '0;
      if (req_int[i] && !bus.grant[i]) begin
        wait_next[i] = (wait_cnt[i] < LIM) ? wait_cnt[i] + WAIT_W'(1) : wait_cnt[i];
      end
    end
  end

  // Pending counters: accept increments, consume decrements, both together cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) pending[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (accept[i] && !consume[i])      pending[i] <= pending[i] + CNT_W'(1);
        else if (consume[i] && !accept[i]) pending[i] <= pending[i] - CNT_W'(1);
      end
    end
  end

  // Wait counters and the starvation flags derived from their next value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
      starve_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        wait_cnt[i] <= wait_next[i];
        starve_q[i] <= (wait_next[i] >= LIM);
      end
    end
  end

  // Completion pulse; the id is held between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
    end else begin
      done_valid_q <= |consume;
      if (|consume) done_id_q <= first_idx;
    end
  end

  // Sticky protocol errors; a fresh violation beats a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_spurious_q <= 1'b0;
      err_multi_q    <= 1'b0;
    end else begin
      if (spurious_hit)     err_spurious_q <= 1'b1;
      else if (bus.clr_err) err_spurious_q <= 1'b0;
      if (multi_hit)        err_multi_q    <= 1'b1;
      else if (bus.clr_err) err_multi_q    <= 1'b0;
    end
  end

  // Drive the bus outputs.
  always_comb begin
    bus.job_ready = '0;
    for (int i = 0; i < N; i++) bus.job_ready[i] = (pending[i] != MAX_CNT);
  end

  assign bus.req          = req_int;
  assign bus.starve       = starve_q;
  assign bus.done_valid   = done_valid_q;
  assign bus.done_id      = done_id_q;
  assign bus.err_spurious = err_spurious_q;
  assign bus.err_multi    = err_multi_q;

endmodule

// File: tb/tb_rr_req_agent.sv
// Directed bench for rr_req_agent: expected completion ids go into a scoreboard queue as
// grants are issued; a monitor pops and compares on every done pulse.
module tb_rr_req_agent;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  rr_req_agent_if #(.N(4), .IDX_W(2)) bus ();

  rr_req_agent #(.N(4), .CNT_W(4), .STARVE_LIM(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Drive inputs at a falling edge, then let one rising edge pass.
  task automatic applyStimulus(input logic [3:0] jv, input logic [3:0] gr, input logic ce);
    bus.job_valid = jv;
    bus.grant     = gr;
    bus.clr_err   = ce;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected id.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL done_unexpected actual=id%0d expected=no_pulse", bus.done_id);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          if (bus.done_id !== e) begin
            failures++;
            $display("[TB] FAIL done_id actual=%0d expected=%0d", bus.done_id, e);
          end
        end
      end
    end
  end

  // Global time bound.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.job_valid = '0;
    bus.grant     = '0;
    bus.clr_err   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("por_req", bus.req, 4'b0000);
    checkOutput("por_job_ready", bus.job_ready, 4'b1111);
    checkOutput("por_done_valid", bus.done_valid, 1'b0);
    checkOutput("por_done_id", bus.done_id, 2'd0);
    checkOutput("por_starve", bus.starve, 4'b0000);

    // 1: traffic, a multi-hot grant, then reset mid-run
    $display("[TB] test 1 reset mid-traffic");
    repeat (2) applyStimulus(4'b1111, 4'b0000, 1'b0);
    checkOutput("t1_req_loaded", bus.req, 4'b1111);
    exp_q.push_back(2'd0);
    applyStimulus(4'b0000, 4'b0011, 1'b0);
    checkOutput("t1_req_granted", bus.req, 4'b1100);
    checkOutput("t1_err_multi", bus.err_multi, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("t1_req_idle", bus.req, 4'b1111);
    reset = 1'b1;
    #1;
    checkOutput("t1_rst_req", bus.req, 4'b0000);
    checkOutput("t1_rst_job_ready", bus.job_ready, 4'b1111);
    checkOutput("t1_rst_err_multi", bus.err_multi, 1'b0);
    checkOutput("t1_rst_err_spurious", bus.err_spurious, 1'b0);
    checkOutput("t1_rst_done_valid", bus.done_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // 2: three jobs on ch2, grant held three cycles
    $display("[TB] test 2 single channel");
    repeat (3) applyStimulus(4'b0100, 4'b0000, 1'b0);
    checkOutput("t2_req_loaded", bus.req, 4'b0100);
    exp_q.push_back(2'd2);
    applyStimulus(4'b0000, 4'b0100, 1'b0);
    checkOutput("t2_req_g1", bus.req, 4'b0100);
    exp_q.push_back(2'd2);
    applyStimulus(4'b0000, 4'b0100, 1'b0);
    checkOutput("t2_req_g2", bus.req, 4'b0000);
    exp_q.push_back(2'd2);
    applyStimulus(4'b0000, 4'b0100, 1'b0);
    checkOutput("t2_req_g3", bus.req, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("t2_err_spurious", bus.err_spurious, 1'b0);
    checkOutput("t2_req_after", bus.req, 4'b0000);

    // 3: saturate ch0 at 15, 16th offer dropped, then drain exactly 15
    $display("[TB] test 3 saturation");
    repeat (15) applyStimulus(4'b0001, 4'b0000, 1'b0);
    checkOutput("t3_ready_full", bus.job_ready, 4'b1110);
    checkOutput("t3_req_full", bus.req, 4'b0001);
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    checkOutput("t3_ready_16th", bus.job_ready, 4'b1110);
    exp_q.push_back(2'd0);
    applyStimulus(4'b0000, 4'b0001, 1'b0);
    checkOutput("t3_ready_after_grant", bus.job_ready, 4'b1111);
    for (int k = 0; k < 14; k++) begin
      exp_q.push_back(2'd0);
      applyStimulus(4'b0000, 4'b0001, 1'b0);
    end
    checkOutput("t3_req_drained", bus.req, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("t3_err_spurious", bus.err_spurious, 1'b0);

    // 4: accept and consume together on ch1 at pending=5
    $display("[TB] test 4 simultaneous accept and consume");
    repeat (5) applyStimulus(4'b0010, 4'b0000, 1'b0);
    exp_q.push_back(2'd1);
    applyStimulus(4'b0010, 4'b0010, 1'b0);
    checkOutput("t4_req", bus.req, 4'b0010);
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(2'd1);
      applyStimulus(4'b0000, 4'b0010, 1'b0);
    end
    checkOutput("t4_req_drained", bus.req, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("t4_err_spurious", bus.err_spurious, 1'b0);

    // 5: multi-hot and spurious grants, clear, and set-beats-clear
    $display("[TB] test 5 protocol errors");
    applyStimulus(4'b0101, 4'b0000, 1'b0);
    exp_q.push_back(2'd0);
    applyStimulus(4'b0000, 4'b0101, 1'b0);
    checkOutput("t5_err_multi", bus.err_multi, 1'b1);
    checkOutput("t5_no_spurious", bus.err_spurious, 1'b0);
    checkOutput("t5_req_after_multi", bus.req, 4'b0000);
    applyStimulus(4'b0000, 4'b1000, 1'b0);
    checkOutput("t5_err_spurious", bus.err_spurious, 1'b1);
    checkOutput("t5_err_multi_sticky", bus.err_multi, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("t5_clr_spurious", bus.err_spurious, 1'b0);
    checkOutput("t5_clr_multi", bus.err_multi, 1'b0);
    applyStimulus(4'b0000, 4'b1000, 1'b1);
    checkOutput("t5_set_wins", bus.err_spurious, 1'b1);
    checkOutput("t5_multi_stays_clear", bus.err_multi, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("t5_clr_again", bus.err_spurious, 1'b0);

    // 6: ch3 requests unserved for 16 cycles, then gets served
    $display("[TB] test 6 starvation");
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    repeat (15) applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("t6_starve_15", bus.starve, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("t6_starve_16", bus.starve, 4'b1000);
    exp_q.push_back(2'd3);
    applyStimulus(4'b0000, 4'b1000, 1'b0);
    checkOutput("t6_starve_cleared", bus.starve, 4'b0000);
    checkOutput("t6_req", bus.req, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("t6_err_spurious", bus.err_spurious, 1'b0);
    checkOutput("t6_done_id_held", bus.done_id, 2'd3);

    repeat (2) applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
